// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: endpoint of the remote command link on the Knight side.
// Receives 8N1 UART bytes, pairs them into 16-bit commands (high byte first)
// and sends 8-bit response bytes back to the remote.
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   RX / TX      - serial in (asynchronous, idles high) / serial out (idles high)
//   cmd, cmd_rdy - last complete command and its unconsumed flag
//   clr_cmd_rdy  - consumer acknowledge; clears cmd_rdy
//   resp         - response byte to send
//   send_resp    - one-cycle request to send resp
//   resp_sent    - one-cycle pulse when the stop bit of a response finishes
//   tx_busy      - high while a response frame is on the wire
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy
);
  localparam int unsigned CNT_W = 12;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] FULL_MAX = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  typedef enum logic {AS_WAIT_HI, AS_WAIT_LO} as_state_t;
  typedef enum logic {TX_IDLE, TX_BITS} tx_state_t;

  logic             r_rx_ff1, r_rx_ff2, r_rx_prev;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [BIT_W-1:0] r_rx_bits;
  logic [7:0]       r_rx_shift;
  logic             r_byte_rdy, r_frm_err;

  as_state_t        r_as_state;
  logic [7:0]       r_cmd_hi;

  tx_state_t        r_tx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [BIT_W-1:0] r_tx_bits;
  logic [8:0]       r_tx_shift;

  // RX synchroniser; r_rx_prev is only used for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ff1  <= 1'b1;
      r_rx_ff2  <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_ff1  <= RX;
      r_rx_ff2  <= r_rx_ff1;
      r_rx_prev <= r_rx_ff2;
    end
  end

  // RX bit FSM: half-bit start check, then mid-bit sampling of data and stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_byte_rdy <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_byte_rdy <= 1'b0;
      r_frm_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt  <= '0;
          r_rx_bits <= '0;
          if (r_rx_prev && !r_rx_ff2) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == HALF_MAX) begin
            r_rx_cnt   <= '0;
            // line back high at mid start bit means it was a glitch
            r_rx_state <= r_rx_ff2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == FULL_MAX) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_ff2, r_rx_shift[7:1]};
            if (r_rx_bits == BIT_W'(7)) begin
              r_rx_bits  <= '0;
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_bits <= r_rx_bits + BIT_W'(1);
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == FULL_MAX) begin
            r_rx_cnt <= '0;
            if (r_rx_ff2) begin
              r_byte_rdy <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_frm_err  <= 1'b1;
              r_rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: if (r_rx_ff2) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Byte pairing into cmd; pair completion beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_as_state <= AS_WAIT_HI;
      r_cmd_hi   <= '0;
      cmd        <= '0;
      cmd_rdy    <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      case (r_as_state)
        AS_WAIT_HI: begin
          if (r_byte_rdy) begin
            r_cmd_hi   <= r_rx_shift;
            cmd_rdy    <= 1'b0;
            r_as_state <= AS_WAIT_LO;
          end
        end
        AS_WAIT_LO: begin
          if (r_byte_rdy) begin
            cmd        <= {r_cmd_hi, r_rx_shift};
            cmd_rdy    <= 1'b1;
            r_as_state <= AS_WAIT_HI;
          end else if (r_frm_err) begin
            r_as_state <= AS_WAIT_HI;
          end
        end
        default: r_as_state <= AS_WAIT_HI;
      endcase
    end
  end

  // TX FSM: start bit, 8 data bits LSB first, stop bit, each BAUD_DIV clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_shift <= '1;
      TX         <= 1'b1;
      tx_busy    <= 1'b0;
      resp_sent  <= 1'b0;
    end else begin
      resp_sent <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (send_resp) begin
            r_tx_shift <= {1'b1, resp};
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            TX         <= 1'b0;
            tx_busy    <= 1'b1;
            r_tx_state <= TX_BITS;
          end
        end
        TX_BITS: begin
          if (r_tx_cnt == FULL_MAX) begin
            r_tx_cnt <= '0;
            // r_tx_bits is the index of the bit currently on the line
            if (r_tx_bits == BIT_W'(9)) begin
              resp_sent  <= 1'b1;
              tx_busy    <= 1'b0;
              r_tx_state <= TX_IDLE;
            end else begin
              TX         <= r_tx_shift[0];
              r_tx_shift <= {1'b1, r_tx_shift[8:1]};
              r_tx_bits  <= r_tx_bits + BIT_W'(1);
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cmd_wrapper.md
Name: uart_cmd_wrapper

Overview:
- Knight-side endpoint of the remote command link.
- Deserialises UART bytes from the remote into 16-bit commands (high byte first) and presents them to the command processor with a ready/clear handshake.
- Serialises 8-bit responses (0xA5 positive ack, 0x5A move ack) back to the remote.
- Sits between the RX/TX pins and cmd_proc inside KnightsTour; contains its own bit-level UART receiver and transmitter (8N1, LSB first).

Parameters:
- BAUD_DIV, 2604, clocks per bit (19200 baud at 50 MHz); legal range 8..4095.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- RX  input  1  serial in from remote; asynchronous to clk, idles high
- TX  output  1  serial out to remote; idles high
- cmd  output  16  last complete command; {first byte, second byte}
- cmd_rdy  output  1  high when cmd holds an unconsumed command
- clr_cmd_rdy  input  1  consumer clears cmd_rdy
- resp  input  8  response byte to send
- send_resp  input  1  one-cycle request to transmit resp
- resp_sent  output  1  one-cycle pulse when the stop bit of a response finishes
- tx_busy  output  1  high while a frame is being transmitted

Behaviour:
- Reset values:
  - TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, tx_busy=0.
  - RX synchroniser flops preset to 1.
  - All FSMs return to IDLE; all counters cleared.
- Reset mid-frame aborts either direction immediately. TX returns high on the asserting edge.
- RX synchroniser: two flops. All RX logic uses the second flop.
- RX bit FSM:
  - IDLE -> START on synchronised falling edge.
  - START: wait BAUD_DIV/2 clocks (integer division), resample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every BAUD_DIV clocks, 8 bits, LSB first, shift right into an 8-bit register.
  - STOP: sample after BAUD_DIV clocks. A 1 is a valid byte: pulse internal byte_rdy for one clock, go to IDLE. A 0 is a framing error: discard the byte, pulse internal frm_err, wait for RX high, then IDLE.
- Byte assembly FSM:
  - WAIT_HI: on byte_rdy, store the byte as the high half (held internally). Clear cmd_rdy in the same cycle. Go to WAIT_LO.
  - WAIT_LO: on byte_rdy, load cmd = {high, byte} and set cmd_rdy on the next clock edge, i.e. 1 clock after byte_rdy. Go to WAIT_HI. On frm_err, go back to WAIT_HI and keep the stored high half unused.
  - cmd keeps its old value until a full pair completes.
- cmd_rdy:
  - Set by pair completion. Cleared by clr_cmd_rdy or by acceptance of a new high byte.
  - If set and clr occur in the same cycle, set wins.
- TX FSM:
  - IDLE: on send_resp, latch resp, assert tx_busy, drive start bit 0.
  - Frame is 10 bits (0, d0..d7, 1), each held exactly BAUD_DIV clocks.
  - After the stop bit's BAUD_DIV clocks: resp_sent pulses 1 clock, tx_busy drops in the same cycle, return to IDLE.
  - send_resp while tx_busy is ignored. The in-flight frame is unaffected and no request is queued.
  - send_resp in the same cycle as resp_sent is accepted and starts the next frame on the following clock.
  - Transmit latency from send_resp to the TX falling edge: 1 clock. Frame length is exactly 10*BAUD_DIV clocks.
- RX and TX are fully independent (full duplex). Simultaneous receive and transmit is legal.
- Counter widths: 12-bit baud counter, 4-bit bit counter. No wrap beyond the counts defined above.

Test Plan:
- Reset behaviour: BAUD_DIV=16. Assert rst mid-TX-frame -> TX=1 immediately. After release, cmd=0000, cmd_rdy=0, tx_busy=0.
- Command receive: remote sends bytes 0x60 then 0x20 -> cmd=16'h6020, cmd_rdy=1 within 2 clocks of the second stop-bit mid-sample. clr_cmd_rdy pulse -> cmd_rdy=0, cmd still 6020.
- Overwrite and set-wins: with cmd_rdy left high, send 0x29,0x02. cmd_rdy drops on acceptance of 0x29, then cmd=2902 with cmd_rdy=1. Assert clr_cmd_rdy in the completion cycle -> cmd_rdy=1.
- Framing error and glitch recovery: send 0x40 with stop bit forced 0, then 0x12,0x34 -> cmd=1234, never 40xx. Separately, a 3-clock low glitch on RX -> no byte received.
- Response transmit: send_resp with resp=0xA5 -> TX shows 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing. resp_sent pulses once at clock 160 after start (BAUD_DIV=16). send_resp=0x5A issued mid-frame -> ignored.
- Back-to-back and full duplex: issue 0x5A on the resp_sent cycle while simultaneously receiving 0x6020 -> both frames are correct, with no gap between TX frames.
